// File: rtl/misr_pkg.sv
// Shared defaults for the multiple-input signature register and its test infrastructure.
// Values select a 6-bit compactor with tap mask 6'b100100 and an all-zero seed.
package misr_pkg;

    localparam int MISR_WIDTH = 6;
    localparam int MISR_POLY  = 100;
    localparam int MISR_SEED  = 0;

endpackage : misr_pkg

// File: rtl/misr_if.sv
// Signal bundle for driving and observing a MISR (enable, clear, response word, signature).
// The compactor itself keeps flat ports; this bundle serves drivers and monitors around it.
interface misr_if #(
    parameter int WIDTH = 6
);

    logic             en;
    logic             clr;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] sig;

    modport master (
        output en,
        output clr,
        output din,
        input  sig
    );

    modport slave (
        input  en,
        input  clr,
        input  din,
        output sig
    );

endinterface : misr_if

// File: rtl/misr.sv
// Galois-form multiple-input signature register: compacts one WIDTH-bit response word per enabled clock.
// The MSB is the feedback source and din[i] always feeds stage i.
module misr
    import misr_pkg::*;
#(
    parameter int WIDTH = MISR_WIDTH,
    parameter int POLY  = MISR_POLY,
    parameter int SEED  = MISR_SEED
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sig,
    input  logic             en,
    input  logic             clr
);

    // Bits of POLY and SEED above WIDTH-1 are deliberately dropped here.
    localparam logic [WIDTH-1:0] TAPS     = POLY[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_VAL = SEED[WIDTH-1:0];

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("misr: WIDTH must lie in 2..32");
        end
    endgenerate

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next;

    assign w_next[0] = din[0] ^ (r_q[WIDTH-1] & TAPS[0]);

    genvar gi;
    generate
        for (gi = 1; gi < WIDTH; gi++) begin : g_stage
            assign w_next[gi] = r_q[gi-1] ^ din[gi] ^ (r_q[WIDTH-1] & TAPS[gi]);
        end
    endgenerate

    // Clear outranks enable; reset outranks both and acts without a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= SEED_VAL;
        end else if (clr) begin
            r_q <= SEED_VAL;
        end else if (en) begin
            r_q <= w_next;
        end
    end

    assign sig = r_q;

endmodule : misr

// File: tb/tb_misr.sv
// Self-checking bench for misr at WIDTH=6, POLY=100, SEED=0.
// Expected signatures come from an independent model and are queued per driven cycle.
module tb_misr;
    import misr_pkg::*;

    localparam int W = MISR_WIDTH;

    logic clk = 1'b0;
    logic reset;

    misr_if #(.WIDTH(W)) bus ();

    misr #(
        .WIDTH(W),
        .POLY (MISR_POLY),
        .SEED (MISR_SEED)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .din  (bus.din),
        .sig  (bus.sig),
        .en   (bus.en),
        .clr  (bus.clr)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [5:0] modelQ;
    logic [5:0] expQ[$];
    logic [5:0] streamA[65];
    logic [5:0] streamB[65];
    logic [5:0] sigA;
    logic [5:0] sigB;
    logic [5:0] singleExp[6];

    function automatic logic [5:0] modelStep(logic [5:0] q, logic [5:0] d, logic e, logic c);
        if (c) return 6'b000000;
        if (!e) return q;
        return {q[4:0], 1'b0} ^ d ^ (q[5] ? 6'b100100 : 6'b000000);
    endfunction

    task automatic checkOutput(input string tag, input logic [5:0] observed, input logic [5:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
        end
    endtask

    // Drives one cycle, queues the model's answer, then compares after the edge.
    task automatic applyStimulus(input string tag, input logic e, input logic c, input logic [5:0] d);
        logic [5:0] exp;
        bus.en  = e;
        bus.clr = c;
        bus.din = d;
        modelQ  = modelStep(modelQ, d, e, c);
        expQ.push_back(modelQ);
        @(posedge clk);
        #1;
        if (expQ.size() == 0) begin
            checkOutput({tag, "_empty"}, bus.sig, 6'bxxxxxx);
        end else begin
            exp = expQ.pop_front();
            checkOutput(tag, bus.sig, exp);
        end
    endtask

    initial begin
        singleExp = '{6'b000001, 6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b100000};

        reset   = 1'b0;
        bus.en  = 1'b1;
        bus.clr = 1'b0;
        bus.din = 6'b111111;
        #3;
        checkOutput("reset_async", bus.sig, 6'b000000);
        @(posedge clk);
        #1;
        checkOutput("reset_hold_edge", bus.sig, 6'b000000);
        reset  = 1'b1;
        modelQ = 6'b000000;

        applyStimulus("single_0", 1'b1, 1'b0, 6'b000001);
        checkOutput("single_lit_0", bus.sig, singleExp[0]);
        for (int i = 1; i < 6; i++) begin
            applyStimulus("single", 1'b1, 1'b0, 6'b000000);
            checkOutput($sformatf("single_lit_%0d", i), bus.sig, singleExp[i]);
        end

        applyStimulus("feedback", 1'b1, 1'b0, 6'b000000);
        checkOutput("feedback_lit", bus.sig, 6'b100100);

        for (int i = 0; i < 4; i++) begin
            applyStimulus("hold", 1'b0, 1'b0, (i % 2 == 0) ? 6'b101010 : 6'b010101);
            checkOutput("hold_lit", bus.sig, 6'b100100);
        end
        applyStimulus("clear", 1'b1, 1'b1, 6'b111111);
        checkOutput("clear_lit", bus.sig, 6'b000000);

        for (int i = 0; i < 65; i++) begin
            streamA[i] = 6'($urandom_range(0, 63));
            streamB[i] = 6'($urandom_range(0, 63));
        end

        for (int i = 0; i < 65; i++) applyStimulus("streamA", 1'b1, 1'b0, streamA[i]);
        sigA = modelQ;
        applyStimulus("clrA", 1'b0, 1'b1, 6'b000000);
        for (int i = 0; i < 65; i++) applyStimulus("streamB", 1'b1, 1'b0, streamB[i]);
        sigB = modelQ;
        applyStimulus("clrB", 1'b0, 1'b1, 6'b000000);
        for (int i = 0; i < 65; i++) applyStimulus("streamAB", 1'b1, 1'b0, streamA[i] ^ streamB[i]);
        checkOutput("linearity", bus.sig, sigA ^ sigB);

        applyStimulus("clrErr", 1'b1, 1'b1, 6'b000000);
        begin
            int errWord;
            int errBit;
            errWord = int'($urandom_range(0, 64));
            errBit  = int'($urandom_range(0, 5));
            for (int i = 0; i < 65; i++) begin
                applyStimulus("streamErr", 1'b1, 1'b0,
                              (i == errWord) ? (streamA[i] ^ 6'(1 << errBit)) : streamA[i]);
            end
        end
        checkOutput("error_detect", {5'b00000, (bus.sig != sigA)}, 6'b000001);

        for (int i = 0; i < 5; i++) applyStimulus("preReset", 1'b1, 1'b0, 6'b110011);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("reset_mid", bus.sig, 6'b000000);
        @(posedge clk);
        #1;
        reset  = 1'b1;
        modelQ = 6'b000000;
        applyStimulus("post_reset", 1'b1, 1'b0, 6'b000011);
        checkOutput("post_reset_lit", bus.sig, 6'b000011);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule : tb_misr

// File: doc/misr.md
MISR -- requirements
Module: misr

Interface
REQ-001 SHALL have parameter WIDTH, default 6: signature and data width in bits, legal range 2..32.
REQ-002 SHALL have parameter POLY, default 100 (decimal), integer: feedback tap mask, only bits [WIDTH-1:0] used; 100 with WIDTH=6 gives mask 6'b100100.
REQ-003 SHALL have parameter SEED, default 0: signature value loaded on reset and on clear.
REQ-004 SHALL list parameters positionally in the order WIDTH, POLY, SEED.
REQ-005 SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port en, input, 1 bit: compaction enable; when low, the signature holds.
REQ-008 SHALL have port clr, input, 1 bit: synchronous reload of SEED.
REQ-009 SHALL have port din, input, WIDTH bits: parallel response word to compact.
REQ-010 SHALL have port sig, output, WIDTH bits: current signature, driven directly from the state register.
REQ-011 SHALL keep the first four ports in the order clk, reset, din, sig; en and clr follow.

Function
REQ-012 SHALL hold WIDTH-bit state q; sig = q at all times, with no combinational path from din to sig.
REQ-013 SHALL, on each rising clk edge with reset high, clr=0 and en=1, load the Galois-MISR update below.
REQ-014 Update for bit 0: q'[0] = din[0] ^ (q[WIDTH-1] & POLY[0]).
REQ-015 Update for bits 1..WIDTH-1: q'[i] = q[i-1] ^ din[i] ^ (q[WIDTH-1] & POLY[i]).
REQ-016 SHALL make the update one cycle latency: din sampled at edge k appears in sig after edge k.
REQ-017 SHALL hold q unchanged when en=0 and clr=0.
REQ-018 SHALL load SEED[WIDTH-1:0] on a rising edge with clr=1, regardless of en; clr has priority over en.
REQ-019 SHALL make the result independent of din X/Z only when en=0 or clr=1; otherwise X propagates, with no masking.
REQ-020 SHALL ignore POLY and SEED bits above WIDTH-1, with no warning required.
REQ-021 SHALL keep bit-ordering fixed: din[i] always feeds stage i, and the MSB q[WIDTH-1] is the feedback source.

Reset
REQ-022 SHALL, while reset=0, force q = SEED[WIDTH-1:0] immediately and asynchronously, overriding clr and en.
REQ-023 SHALL resume compaction on the first rising edge after reset deasserts; deassertion is assumed synchronous to clk.
REQ-024 SHALL make reset mid-sequence discard all accumulated signature.

Structure
REQ-025 SHALL be a single flat module; no sub-module.
REQ-026 SHALL place default constants MISR_WIDTH=6, MISR_POLY=100 and MISR_SEED=0 in the shared test-infrastructure package; the module itself uses no typedefs.
REQ-027 SHALL implement the update as a generate loop over stages plus one always block for the register, with elaboration-time parameter range checks (about 120 lines including checks).

Verification (WIDTH=6, POLY=100, SEED=0)
REQ-028 Reset test: reset=0 with din=6'b111111 and en=1 -> sig=000000 immediately, no clk edge needed.
REQ-029 Single-bit test: en=1; din=000001 for one edge, then 000000 for 5 edges -> sig=000001, 000010, 000100, 001000, 010000, 100000.
REQ-030 Feedback test: from sig=100000, din=000000 for one edge -> sig=100100 (MSB shifted out, mask applied).
REQ-031 Hold and clear test: en=0 with din toggling -> sig unchanged; then clr=1 with en=1 -> sig=SEED=000000 after the edge.
REQ-032 Linearity test: the signature of stream A XOR stream B equals sig(A) XOR sig(B) for 65 random 6-bit words, starting from SEED=0.
REQ-033 Error-detect test: flip one bit of one word in a 65-word stream -> final sig differs from the golden signature.
